// File: rtl/trace_pkg.sv
// Shared constants for the pipeline trace buffer: FSM state encoding and stamp width.
package trace_pkg;

  localparam int TRC_STAMP_W = 16;

  typedef enum logic [1:0] {
    TRC_IDLE    = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_CAPTURE = 2'd2,
    TRC_DONE    = 2'd3
  } trc_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered occupancy count.
// A push against a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Trigger-started capture of (trace_a, trace_b[, stamp]) snapshots into a FIFO drained by valid/ready.
// Define TRACE_STAMP_EN to build the 16-bit cycle counter and store a stamp per entry.
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 32,
  parameter int CAPTURE_LEN = 16
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   arm,
  input  logic [DATA_W-1:0]      trig_value,
  input  logic [DATA_W-1:0]      trig_mask,
  input  logic                   trace_valid,
  input  logic [DATA_W-1:0]      trace_a,
  input  logic [DATA_W-1:0]      trace_b,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_a,
  output logic [DATA_W-1:0]      rd_b,
  output logic [TRC_STAMP_W-1:0] rd_stamp,
  output logic [1:0]             state,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef TRACE_STAMP_EN
  localparam int ENTRY_W = 2 * DATA_W + TRC_STAMP_W;
`else
  localparam int ENTRY_W = 2 * DATA_W;
`endif
  localparam logic [CW-1:0] LEN_C   = CW'(CAPTURE_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  trc_state_e       state_reg, state_next;
  logic [CW-1:0]    wr_count_reg, wr_count_next;
  logic             overflow_reg;
  logic             arm_clear;
  logic             trig_hit, want_write, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [ENTRY_W-1:0] wdata, head, last_reg, shown;

`ifdef TRACE_STAMP_EN
  logic [TRC_STAMP_W-1:0] cycle_cnt_reg;

  always_ff @(posedge clock) begin
    if (ctrl_reset) cycle_cnt_reg <= '0;
    else            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
  end

  assign wdata    = {trace_a, trace_b, cycle_cnt_reg};
  assign rd_stamp = shown[TRC_STAMP_W-1:0];
`else
  assign wdata    = {trace_a, trace_b};
  assign rd_stamp = '0;
`endif

  // The triggering snapshot is written in the same cycle it matches.
  assign trig_hit   = (state_reg == TRC_ARMED) && trace_valid &&
                      (((trace_a ^ trig_value) & trig_mask) == '0);
  assign want_write = trace_valid &&
                      (trig_hit || ((state_reg == TRC_CAPTURE) && (wr_count_reg < LEN_C)));
  assign pop        = !fifo_empty && rd_ready;
  assign push       = want_write && (!fifo_full || pop);
  assign wr_count_next = wr_count_reg + {{(CW-1){1'b0}}, push};

  trace_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk   (clock),
    .srst  (ctrl_reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    arm_clear  = 1'b0;
    case (state_reg)
      TRC_IDLE: begin
        if (arm) begin
          state_next = TRC_ARMED;
          arm_clear  = 1'b1;
        end
      end
      TRC_ARMED: begin
        if (trig_hit) state_next = TRC_CAPTURE;
      end
      TRC_CAPTURE: begin
        if ((wr_count_next >= LEN_C) || (wr_count_next == DEPTH_C)) state_next = TRC_DONE;
      end
      TRC_DONE: begin
        if (fifo_empty || (pop && (fifo_count == CW'(1)))) state_next = TRC_IDLE;
      end
      default: state_next = TRC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_reg    <= TRC_IDLE;
      wr_count_reg <= '0;
      overflow_reg <= 1'b0;
      last_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (arm_clear) begin
        wr_count_reg <= '0;
        overflow_reg <= 1'b0;
      end else begin
        wr_count_reg <= wr_count_next;
        if (want_write && !push) overflow_reg <= 1'b1;
      end
      if (!fifo_empty) last_reg <= head;
    end
  end

  // Outputs keep showing the most recently presented entry once the FIFO drains.
  assign shown    = fifo_empty ? last_reg : head;
  assign rd_valid = !fifo_empty;
  assign rd_a     = shown[ENTRY_W-1 -: DATA_W];
  assign rd_b     = shown[ENTRY_W-DATA_W-1 -: DATA_W];
  assign state    = state_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and a random run
// compared every cycle against a queue-based reference model.
module tb_pipeline_trace_buffer;

  localparam int DEPTH = 4;
  localparam int LEN   = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset, arm, trace_valid, rd_ready;
  logic [31:0] trig_value, trig_mask, trace_a, trace_b;
  logic        rd_valid, overflow;
  logic [31:0] rd_a, rd_b;
  logic [15:0] rd_stamp;
  logic [1:0]  state;

  always #5 clock = ~clock;

  pipeline_trace_buffer #(
    .DEPTH(DEPTH),
    .DATA_W(32),
    .CAPTURE_LEN(LEN)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .arm(arm),
    .trig_value(trig_value), .trig_mask(trig_mask),
    .trace_valid(trace_valid), .trace_a(trace_a), .trace_b(trace_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_a(rd_a), .rd_b(rd_b), .rd_stamp(rd_stamp),
    .state(state), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] stamp;
  } entry_t;

  typedef struct packed {
    logic        arm;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic [1:0]  exp_state;
    logic        exp_rv;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  entry_t      q[$];
  entry_t      m_last;
  int          m_state;
  int          m_cnt;
  bit          m_ovf;
  logic [15:0] m_ctr;
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge of the session rules, using the inputs applied this cycle.
  task automatic model_edge();
    int     sz;
    bit     popped, trig, want;
    int     old_state;
    entry_t e;
    if (ctrl_reset) begin
      q.delete();
      m_state = 0; m_cnt = 0; m_ovf = 0; m_ctr = 16'd0;
      m_last = '{a: 32'd0, b: 32'd0, stamp: 16'd0};
      return;
    end
    old_state = m_state;
    sz        = q.size();
    popped    = (sz > 0) && rd_ready;
    if (sz > 0) m_last = q[0];
    trig = (old_state == 1) && trace_valid && (((trace_a ^ trig_value) & trig_mask) == 32'd0);
    want = trace_valid && (trig || (old_state == 2 && m_cnt < LEN));
    if (popped) q.delete(0);
    if (want) begin
      if (q.size() < DEPTH) begin
        e = '{a: trace_a, b: trace_b, stamp: m_ctr};
        q.push_back(e);
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
    case (old_state)
      0: if (arm) begin m_state = 1; m_cnt = 0; m_ovf = 0; end
      1: if (trig) m_state = 2;
      2: if (m_cnt >= LEN || m_cnt == DEPTH) m_state = 3;
      default: if (sz == 0 || (popped && sz == 1)) m_state = 0;
    endcase
    m_ctr = m_ctr + 16'd1;
  endtask

  task automatic check_model();
    entry_t h;
    if (q.size() > 0) h = q[0];
    else              h = m_last;
    chk("state", 32'(state), 32'(m_state));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_a", rd_a, h.a);
    chk("rd_b", rd_b, h.b);
`ifdef TRACE_STAMP_EN
    chk("rd_stamp", 32'(rd_stamp), 32'(h.stamp));
`else
    chk("rd_stamp", 32'(rd_stamp), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    step();
    ctrl_reset  = 1'b0;
    arm         = 1'b0;
    trace_valid = 1'b0;
    rd_ready    = 1'b0;
  endtask

  task automatic run_table();
    trig_value = 32'd5;
    trig_mask  = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      arm         = tbl[i].arm;
      trace_valid = tbl[i].valid;
      trace_a     = tbl[i].a;
      trace_b     = tbl[i].b;
      rd_ready    = tbl[i].ready;
      step();
      $display("vec %0d: state=%0d rd_valid=%0b rd_a=%0d rd_b=%0d", i, state, rd_valid, rd_a, rd_b);
      chk("vec_state", 32'(state), 32'(tbl[i].exp_state));
      chk("vec_rd_valid", 32'(rd_valid), 32'(tbl[i].exp_rv));
      chk("vec_rd_a", rd_a, tbl[i].exp_a);
      chk("vec_rd_b", rd_b, tbl[i].exp_b);
    end
    arm = 1'b0; trace_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    //                arm   vld   a      b       rdy   st    rv    exp_a  exp_b
    tbl[0] = '{1'b1, 1'b0, 32'd0, 32'd0,   1'b0, 2'd1, 1'b0, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd3, 32'd100, 1'b0, 2'd1, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 32'd4, 32'd101, 1'b0, 2'd1, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 32'd5, 32'd102, 1'b0, 2'd2, 1'b1, 32'd5, 32'd102};
    tbl[4] = '{1'b0, 1'b1, 32'd6, 32'd103, 1'b0, 2'd2, 1'b1, 32'd5, 32'd102};
    tbl[5] = '{1'b0, 1'b0, 32'd0, 32'd0,   1'b1, 2'd2, 1'b1, 32'd6, 32'd103};
    tbl[6] = '{1'b0, 1'b0, 32'd0, 32'd0,   1'b1, 2'd2, 1'b0, 32'd6, 32'd103};

    ctrl_reset = 1'b1; arm = 1'b0; trace_valid = 1'b0; rd_ready = 1'b0;
    trig_value = 32'd0; trig_mask = 32'd0; trace_a = 32'd0; trace_b = 32'd0;
    m_ctr = 16'd0; m_state = 0; m_cnt = 0; m_ovf = 0;
    m_last = '{a: 32'd0, b: 32'd0, stamp: 16'd0};

    // Idle with valids but no arm: nothing is captured.
    do_reset();
    trace_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      trace_a = 32'(i);
      step();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_rd_valid", 32'(rd_valid), 32'd0);
      chk("idle_overflow", 32'(overflow), 32'd0);
    end
    trace_valid = 1'b0;

    // Value-match trigger with readback.
    do_reset();
    run_table();

    // Capture-length limit, pop while full in DONE, then drain back to IDLE.
    do_reset();
    trig_mask = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    trace_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      trace_a = 32'(10 + i); trace_b = 32'(200 + i);
      step();
      $display("cap %0d: state=%0d rd_valid=%0b", i, state, rd_valid);
    end
    chk("len_state", 32'(state), 32'd3);
    chk("len_rd_a", rd_a, 32'd10);
    chk("len_overflow", 32'(overflow), 32'd0);
    trace_a = 32'd99; rd_ready = 1'b1;
    step();
    chk("full_pop_overflow", 32'(overflow), 32'd0);
    chk("full_pop_rd_a", rd_a, 32'd11);
    trace_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      $display("drain %0d: state=%0d rd_a=%0d", j, state, rd_a);
      chk("drain_state", 32'(state), (j < 2) ? 32'd3 : 32'd0);
    end
    rd_ready = 1'b0;

    // Reset in the middle of a capture discards everything.
    do_reset();
    trig_mask = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    trace_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trace_a = 32'(40 + i); step();
    end
    trace_valid = 1'b0;
    chk("mid_state", 32'(state), 32'd2);
    ctrl_reset = 1'b1; step(); ctrl_reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_a", rd_a, 32'd0);
    run_table();

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ctrl_reset  = ($urandom_range(0, 199) == 0);
      arm         = ($urandom_range(0, 9) == 0);
      trace_valid = ($urandom_range(0, 9) < 6);
      trace_a     = 32'($urandom_range(0, 7));
      trace_b     = $urandom;
      trig_value  = 32'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       trig_mask = 32'd0;
        1:       trig_mask = 32'hFFFF_FFFF;
        default: trig_mask = 32'd3;
      endcase
      rd_ready = ($urandom_range(0, 9) < 4);
      step();
    end
    ctrl_reset = 1'b0; arm = 1'b0; trace_valid = 1'b0; rd_ready = 1'b0;

`ifdef TRACE_STAMP_EN
    // Stamps across the 16-bit counter wrap.
    do_reset();
    while (m_ctr != 16'hFFFE) step();
    trig_mask = 32'd0;
    arm = 1'b1; step(); arm = 1'b0;
    trace_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trace_a = 32'(70 + i); step();
    end
    trace_valid = 1'b0;
    chk("wrap_stamp0", 32'(rd_stamp), 32'h0000_FFFF);
    rd_ready = 1'b1;
    step();
    chk("wrap_stamp1", 32'(rd_stamp), 32'h0000_0000);
    step();
    chk("wrap_stamp2", 32'(rd_stamp), 32'h0000_0001);
    rd_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
On-chip trace capture block that records per-cycle snapshots of decode/execute operand values (e.g. ALU source B and immediate) into a FIFO buffer. A host-side or bench-side consumer drains the buffer through a valid/ready read port. Capture starts on a programmable value-match trigger, so snapshots can be extracted without hierarchical probing. Sits beside the processor core inside the skeleton and is fed from the D/X pipeline register outputs.

Parameters:
DEPTH, 16, number of buffer entries; power of two, at least 2.
DATA_W, 32, width of each traced operand.
CAPTURE_LEN, 16, maximum snapshots written per trigger; range 1..DEPTH.

Ports:
clock  in  1  single system clock; all logic on the posedge.
ctrl_reset  in  1  synchronous, active-high reset.
arm  in  1  one-cycle pulse; starts a capture session from IDLE.
trig_value  in  DATA_W  compare value for the trigger.
trig_mask  in  DATA_W  bit enables for the compare; all-zero mask means trigger on the first valid.
trace_valid  in  1  snapshot present this cycle.
trace_a  in  DATA_W  traced operand A; this is also the trigger source.
trace_b  in  DATA_W  traced operand B.
rd_valid  out  1  head entry available.
rd_ready  in  1  consumer accepts the head entry.
rd_a  out  DATA_W  head entry, operand A.
rd_b  out  DATA_W  head entry, operand B.
rd_stamp  out  16  head entry cycle stamp.
state  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.
overflow  out  1  sticky flag; a snapshot was dropped because the buffer was full.

Behaviour:
- Reset: ctrl_reset is sampled on the clock edge.
  - Reset clears the FIFO and sets state to IDLE.
  - All outputs go to 0: rd_valid, rd_a, rd_b, rd_stamp, state and overflow.
  - The cycle counter clears to 0.
  - Reset mid-session aborts the session and discards all buffered data.
- Cycle counter: 16-bit, free-running, increments every non-reset cycle, wraps 0xFFFF -> 0x0000.
- FSM transitions:
  - IDLE -> ARMED on arm. Arming clears overflow and the session write count.
  - ARMED -> CAPTURE when trace_valid is high and ((trace_a ^ trig_value) & trig_mask) == 0. The triggering snapshot is itself written.
  - CAPTURE -> DONE once the session write count reaches CAPTURE_LEN, or when the write count equals DEPTH.
  - DONE -> IDLE in the cycle the last entry is popped. If the buffer is already empty on entry to DONE, return to IDLE on the next cycle.
  - arm is ignored outside IDLE.
- Write rules:
  - A write occurs when in CAPTURE, or on the trigger cycle, with trace_valid high and the FIFO not full.
  - An entry is {trace_a, trace_b, counter value of that cycle}.
  - If the FIFO is full, the snapshot is dropped, overflow is set, and the session count does not advance.
  - trace_valid is ignored in IDLE, ARMED (non-matching cycles) and DONE.
- Read rules:
  - A pop happens when rd_valid && rd_ready.
  - rd_a, rd_b and rd_stamp are the head entry whenever rd_valid is high, and hold their last value otherwise.
  - Reads are permitted in any state, so draining can overlap capture.
  - Write-to-read latency: an entry written at edge N gives rd_valid = 1 after edge N (visible in cycle N+1).
- Simultaneous push and pop:
  - When the FIFO is full, a simultaneous push and pop is accepted with no overflow; pop-before-push semantics apply.
  - When the FIFO is empty, the pushed entry is not bypassed; rd_valid rises in the next cycle.
- Pointers: log2(DEPTH)+1 bits each, wrapping naturally. Full when the MSBs differ and the remaining bits are equal. Empty when the pointers are equal.

Optional Feature:
TRACE_STAMP_EN.
- Defined: the 16-bit stamp is stored per entry and presented on rd_stamp.
- Undefined: no stamp storage and no cycle counter are built; rd_stamp is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package (trace_pkg) holds:
  - state encoding constants: TRC_IDLE = 2'd0, TRC_ARMED = 2'd1, TRC_CAPTURE = 2'd2, TRC_DONE = 2'd3;
  - the stamp width constant TRC_STAMP_W = 16.
- One sub-module, trace_fifo: parameterised synchronous FIFO with registered pointers and a count, exposing full/empty and push/pop.
- The FSM, trigger compare and counter live in pipeline_trace_buffer.

Test Plan:
1. Reset, then hold arm = 0 with trace_valid = 1 for 10 cycles -> state = 0, rd_valid = 0, overflow = 0 throughout.
2. Arm with mask 0xFFFFFFFF and value 0x00000005. Drive trace_a = 3, 4, 5, 6 with trace_b = 100..103 and rd_ready = 0 -> state goes 1 -> 2 at the trace_a = 5 cycle. Entries read back are (5, 102) then (6, 103). Stamps differ by 1.
3. Set CAPTURE_LEN = 4 and mask 0, then send 6 valids -> exactly 4 entries are stored, state = 3. Draining all 4 returns state to 0 in the cycle of the last pop.
4. Set DEPTH = 4 and CAPTURE_LEN = 4, with rd_ready = 0 and trigger plus 5 valids -> 4 entries stored, state = 3, overflow = 0. Repeat with rd_ready pulsed 1 on the 5th valid while full -> no overflow, and the 5th entry replaces the popped slot.
5. Assert ctrl_reset in the middle of CAPTURE with 3 entries buffered -> next cycle state = 0, rd_valid = 0, overflow = 0. A subsequent arm behaves as in test 2.
6. With TRACE_STAMP_EN defined, advance the counter past 0xFFFE and capture 3 snapshots -> stamps are 0xFFFF, 0x0000, 0x0001. With the macro undefined -> rd_stamp = 0 for all entries.
